// File: rtl/sd_dat_rx_seq_if.sv
// sd_dat_rx_seq_if: bundles the sequencer's sampler, CRC engine and block-side signals.
//   slave  (sequencer): takes i_start/i_abort/i_bit_en/i_dat_in/i_crc_val, drives all o_* signals
//   master (system)   : the mirror image of slave
interface sd_dat_rx_seq_if;
    logic        i_start;
    logic        i_abort;
    logic        i_bit_en;
    logic        i_dat_in;
    logic [15:0] i_crc_val;
    logic [7:0]  o_byte_out;
    logic        o_byte_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_crc_ok;
    logic        o_crc_err;
    logic        o_end_err;
    logic        o_timeout;
    logic        o_crc_bit;
    logic        o_crc_strb;
    logic        o_crc_clear;
    modport slave (
        input  i_start, i_abort, i_bit_en, i_dat_in, i_crc_val,
        output o_byte_out, o_byte_valid, o_busy, o_done, o_crc_ok, o_crc_err,
               o_end_err, o_timeout, o_crc_bit, o_crc_strb, o_crc_clear
    );
    modport master (
        output i_start, i_abort, i_bit_en, i_dat_in, i_crc_val,
        input  o_byte_out, o_byte_valid, o_busy, o_done, o_crc_ok, o_crc_err,
               o_end_err, o_timeout, o_crc_bit, o_crc_strb, o_crc_clear
    );
endinterface

// File: rtl/sd_dat_rx_seq.sv
// sd_dat_rx_seq: SD DAT-line receive sequencer; hunts the start bit, deserialises a block
// MSB-first, streams data and received CRC bits to an external CRC16 engine, then checks the
// residue and end bit.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sd_dat_rx_seq_if.slave (start/abort/bit strobe/data in, CRC engine link, byte/status out)
// Optional start-bit timeout: define SD_DAT_NAC_TIMEOUT_EN (limit set by NAC_MAX).
module sd_dat_rx_seq #(
    parameter int BLK_BYTES = 512,
    parameter int NAC_MAX   = 65535
) (
    input logic           clk,
    input logic           rst_n,
    sd_dat_rx_seq_if.slave bus
);
    localparam int NBITS = BLK_BYTES * 8;
    localparam int CW    = $clog2(NBITS + 16);
    if (BLK_BYTES < 1 || BLK_BYTES > 4096 || NAC_MAX < 1) begin : g_bad_param
        $error("sd_dat_rx_seq: parameter out of range");
    end
    typedef enum logic [2:0] {S_IDLE, S_HUNT, S_DATA, S_CRCR, S_ENDB, S_DONE} state_t;
    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [7:0]      r_shift, w_shift;
    logic [7:0]      r_byte_out, w_byte_out;
    logic            r_byte_valid, w_byte_valid;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic            r_crc_ok, w_crc_ok;
    logic            r_crc_err, w_crc_err;
    logic            r_end_err, w_end_err;
    logic            r_crc_bit, w_crc_bit;
    logic            r_crc_strb, w_crc_strb;
    logic            r_crc_clear, w_crc_clear;
`ifdef SD_DAT_NAC_TIMEOUT_EN
    localparam int NW = $clog2(NAC_MAX + 1);
    logic [NW-1:0]   r_nac, w_nac;
    logic            r_timeout, w_timeout;
`endif
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_shift      = r_shift;
        w_byte_out   = r_byte_out;
        w_byte_valid = 1'b0;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_crc_ok     = r_crc_ok;
        w_crc_err    = r_crc_err;
        w_end_err    = r_end_err;
        w_crc_bit    = 1'b0;
        w_crc_strb   = 1'b0;
        w_crc_clear  = 1'b0;
`ifdef SD_DAT_NAC_TIMEOUT_EN
        w_nac        = r_nac;
        w_timeout    = r_timeout;
`endif
        if (bus.i_abort) begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.i_start) begin
                    // Clear strobe resets the engine before any block bit arrives
                    w_state     = S_HUNT;
                    w_busy      = 1'b1;
                    w_crc_clear = 1'b1;
                    w_crc_strb  = 1'b1;
                    w_crc_ok    = 1'b0;
                    w_crc_err   = 1'b0;
                    w_end_err   = 1'b0;
                    w_cnt       = '0;
`ifdef SD_DAT_NAC_TIMEOUT_EN
                    w_nac       = '0;
                    w_timeout   = 1'b0;
`endif
                end
                S_HUNT: if (bus.i_bit_en) begin
                    if (!bus.i_dat_in) begin
                        w_state = S_DATA;
`ifdef SD_DAT_NAC_TIMEOUT_EN
                    end else if (r_nac == NW'(NAC_MAX - 1)) begin
                        w_state   = S_IDLE;
                        w_timeout = 1'b1;
                        w_done    = 1'b1;
                        w_busy    = 1'b0;
                        w_crc_ok  = 1'b0;
                        w_crc_err = 1'b0;
                    end else begin
                        w_nac = r_nac + NW'(1);
`endif
                    end
                end
                S_DATA, S_CRCR: if (bus.i_bit_en) begin
                    // One counter spans data then CRC bits, so CRCR ends at NBITS+15
                    w_crc_bit  = bus.i_dat_in;
                    w_crc_strb = 1'b1;
                    w_cnt      = r_cnt + CW'(1);
                    if (r_state == S_DATA) begin
                        w_shift      = {r_shift[6:0], bus.i_dat_in};
                        w_byte_valid = (r_cnt[2:0] == 3'd7);
                        w_byte_out   = w_byte_valid ? w_shift : r_byte_out;
                        w_state      = (r_cnt == CW'(NBITS - 1)) ? S_CRCR : S_DATA;
                    end else begin
                        w_state = (r_cnt == CW'(NBITS + 15)) ? S_ENDB : S_CRCR;
                    end
                end
                S_ENDB: if (bus.i_bit_en) begin
                    // CRC_BIT is 0 here, so the lookahead is zero exactly when the register is
                    w_crc_ok  = (bus.i_crc_val == 16'h0000);
                    w_crc_err = (bus.i_crc_val != 16'h0000);
                    w_end_err = !bus.i_dat_in;
                    w_state   = S_DONE;
                end
                S_DONE: begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= 8'h00;
            r_byte_out   <= 8'h00;
            r_byte_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_crc_ok     <= 1'b0;
            r_crc_err    <= 1'b0;
            r_end_err    <= 1'b0;
            r_crc_bit    <= 1'b0;
            r_crc_strb   <= 1'b0;
            r_crc_clear  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_shift      <= w_shift;
            r_byte_out   <= w_byte_out;
            r_byte_valid <= w_byte_valid;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_crc_ok     <= w_crc_ok;
            r_crc_err    <= w_crc_err;
            r_end_err    <= w_end_err;
            r_crc_bit    <= w_crc_bit;
            r_crc_strb   <= w_crc_strb;
            r_crc_clear  <= w_crc_clear;
        end
    end
`ifdef SD_DAT_NAC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nac     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_nac     <= w_nac;
            r_timeout <= w_timeout;
        end
    end
    assign bus.o_timeout = r_timeout;
`else
    assign bus.o_timeout = 1'b0;
`endif
    assign bus.o_byte_out   = r_byte_out;
    assign bus.o_byte_valid = r_byte_valid;
    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_crc_ok     = r_crc_ok;
    assign bus.o_crc_err    = r_crc_err;
    assign bus.o_end_err    = r_end_err;
    assign bus.o_crc_bit    = r_crc_bit;
    assign bus.o_crc_strb   = r_crc_strb;
    assign bus.o_crc_clear  = r_crc_clear;
endmodule

// File: tb/tb_sd_dat_rx_seq.sv
// tb_sd_dat_rx_seq: directed bench for sd_dat_rx_seq with a bit-serial CRC16 engine model
//   (x^16+x^12+x^5+1, init 0) on the engine side of the interface.
module tb_sd_dat_rx_seq;
    localparam int BB = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    sd_dat_rx_seq_if bus ();
    sd_dat_rx_seq #(.BLK_BYTES(BB), .NAC_MAX(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    int strb_cnt = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    logic [7:0]  bq[$];
    logic [15:0] crc_reg = 16'h0;
    logic [15:0] good_crc;
    logic [7:0]  blk [BB] = '{8'h01, 8'h02, 8'h03, 8'h04};
    function automatic logic [15:0] crc_nx(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction
    assign bus.i_crc_val = crc_nx(crc_reg, bus.o_crc_bit);
    always @(posedge clk) if (bus.o_crc_strb) crc_reg <= bus.o_crc_clear ? 16'h0 : bus.i_crc_val;
    always @(negedge clk) begin
        if (bus.o_crc_strb && !bus.o_crc_clear) strb_cnt++;
        if (bus.o_crc_strb && bus.o_crc_clear) clr_cnt++;
        if (bus.o_byte_valid) bq.push_back(bus.o_byte_out);
        if (bus.o_done) done_cnt++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [17:0] outs();
        return {bus.o_byte_out, bus.o_byte_valid, bus.o_busy, bus.o_done, bus.o_crc_ok,
                bus.o_crc_err, bus.o_end_err, bus.o_timeout, bus.o_crc_bit, bus.o_crc_strb,
                bus.o_crc_clear};
    endfunction
    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.i_bit_en = 1'b1;
        bus.i_dat_in = b;
        @(negedge clk);
        bus.i_bit_en = 1'b0;
        bus.i_dat_in = 1'b1;
        @(negedge clk);
    endtask
    task automatic send_data(input int flip, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] by;
            by = blk[i / 8];
            send_bit(by[7 - (i % 8)] ^ (i == flip));
        end
    endtask
    task automatic send_crc(input int n);
        for (int i = 0; i < n; i++) send_bit(good_crc[15 - i]);
    endtask
    task automatic do_start();
        strb_cnt = 0;
        clr_cnt = 0;
        bq.delete();
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        #1;
        check("start_busy_clr_strb_bit", {29'd0, bus.o_busy, bus.o_crc_clear, bus.o_crc_strb}, 32'h7);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask
    task automatic wait_done(input int prev);
        for (int i = 0; i < 60 && done_cnt == prev; i++) begin
            @(negedge clk);
            #1;
        end
        check("done_seen", done_cnt - prev, 1);
    endtask
    task automatic run_block(input string tag, input int flip, input logic endbit, input logic [2:0] exp_flags);
        int d;
        d = done_cnt;
        do_start();
        send_bit(1'b0);
        send_data(flip, BB * 8);
        send_crc(16);
        send_bit(endbit);
        wait_done(d);
        check({tag, "_ok_err_end"}, {29'd0, bus.o_crc_ok, bus.o_crc_err, bus.o_end_err}, {29'd0, exp_flags});
        check({tag, "_busy"}, bus.o_busy, 0);
    endtask
    initial begin
        logic [15:0] c;
        int s, d;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_bit_en = 1'b0;
        bus.i_dat_in = 1'b1;
        c = 16'h0;
        for (int i = 0; i < BB * 8; i++) begin
            logic [7:0] by;
            by = blk[i / 8];
            c = crc_nx(c, by[7 - (i % 8)]);
        end
        good_crc = c;
        #12;
        check("reset_outputs", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block("good", -1, 1'b1, 3'b100);
        check("good_nbytes", bq.size(), 4);
        for (int i = 0; i < 4 && i < bq.size(); i++) check($sformatf("good_byte%0d", i), bq[i], i + 1);
        check("good_strobes", strb_cnt, 48);
        check("good_clears", clr_cnt, 1);
        check("good_timeout", bus.o_timeout, 0);
        run_block("flip", 5, 1'b1, 3'b010);
        run_block("endbit0", -1, 1'b0, 3'b101);
        d = done_cnt;
        do_start();
        send_bit(1'b0);
        send_data(-1, 16);
        check("abort_nbytes", bq.size(), 2);
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("busy_start_ignored", clr_cnt, 1);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        #1;
        check("abort_busy", bus.o_busy, 0);
        s = strb_cnt;
        send_data(-1, 8);
        check("abort_no_strobe", strb_cnt - s, 0);
        check("abort_no_done", done_cnt - d, 0);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        #1;
        check("start_abort_busy", bus.o_busy, 0);
        check("start_abort_no_clear", clr_cnt, 1);
        run_block("after_abort", -1, 1'b1, 3'b100);
        do_start();
        send_bit(1'b0);
        send_data(-1, BB * 8);
        send_crc(5);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", outs(), 0);
        @(negedge clk);
        check("midreset_held", outs(), 0);
        rst_n = 1'b1;
        run_block("after_reset", -1, 1'b1, 3'b100);
        check("after_reset_nbytes", bq.size(), 4);
        d = done_cnt;
        do_start();
        for (int i = 0; i < 10; i++) send_bit(1'b1);
`ifdef SD_DAT_NAC_TIMEOUT_EN
        wait_done(d);
        check("nac_timeout", bus.o_timeout, 1);
        check("nac_ok_err_busy", {29'd0, bus.o_crc_ok, bus.o_crc_err, bus.o_busy}, 0);
`else
        send_bit(1'b1);
        send_bit(1'b1);
        check("nac_busy_held", bus.o_busy, 1);
        check("nac_timeout0", bus.o_timeout, 0);
        check("nac_no_done", done_cnt - d, 0);
        @(negedge clk);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
